pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Parametrised pipeline occupancy tracker and hazard controller for the pipelined processor. It records the valid bit, destination register and load/store class of every instruction from Execute through Writeback. From that record it decides whether Decode may issue, and generates load-use interlocks, memory wait-state stalls, branch flushes and operand-forwarding selects. The register-file write port and the memory handshake are steered from its writeback and stall outputs. This lets the pipeline depth and register count be changed without touching stage logic.

## Interface
- NUM_STAGES, 5, total pipeline stages (Fetch=0, Decode=1, Execute=2, ...); legal range 4..8
- NUM_REGS, 8, architectural registers; REG_BITS = $clog2(NUM_REGS)
- MEM_STAGE, 3, stage index performing data memory access; legal range 3..NUM_STAGES-1
- Derived: D = NUM_STAGES-2 tracked slots; slot j holds the instruction in stage j+2; STAGE_BITS = $clog2(NUM_STAGES)

Ports:
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-high
- Enable  in  1  0 freezes all state
- issue_valid  in  1  Decode holds an instruction
- issue_rd  in  REG_BITS  destination register
- issue_wb  in  1  instruction writes issue_rd
- issue_load, issue_store  in  1  memory class, mutually exclusive
- issue_rx, issue_ry  in  REG_BITS  source registers
- issue_use_rx, issue_use_ry  in  1  source is actually read
- mem_waitreq  in  1  data memory not ready
- flush_req  in  1  taken branch resolved in Execute
- issue_ready  out  1  Decode instruction accepted this cycle
- fwd_x_sel, fwd_y_sel  out  STAGE_BITS  registered; 0 = decode operand, k = forward from stage k
- occupancy  out  D  slot valid bits; bit j = stage j+2
- wb_valid  out  1  last slot valid and writes back
- wb_rd  out  REG_BITS  last slot destination
- stall_cycles  out  16  stall counter (see Configuration)

## Operation
- Slot record: valid, rd, wb, load, store.
- Cycle classes, evaluated in priority order:
  - Frozen: Enable=0.
  - Memory stall: mem_waitreq=1 and slot M=MEM_STAGE-2 is valid with load or store.
  - Flush: flush_req=1.
  - Load-use: see hazard search below.
  - Normal: none of the above.
- Hazard search, for each used source:
  - Find the lowest j with slot j valid, wb=1 and rd=source.
  - If the slot is a load and j+3 <= MEM_STAGE, it is a load-use hazard.
  - Otherwise the source forwards, with sel = j+3 if j+3 < NUM_STAGES, else 0.
  - No match gives sel = 0.
  - Register r0 is not special.
  - The register file is write-through, so the retiring-writer case (sel 0) is correct.
- Slot update per class:
  - Normal: slot0 <= issue (valid=issue_valid); slot j <= slot j-1.
  - Load-use: slot0 <= bubble; the others advance.
  - Flush: the Decode instruction is discarded; slot0 <= bubble; the others advance, so the branch leaves slot0.
  - Memory stall: slots 0..M hold; slot M+1 <= bubble; slots above M+1 advance.
  - Frozen: nothing changes.
- issue_ready = issue_valid in Normal cycles, 0 otherwise.
- flush_req during a Memory stall is ignored. The branch stays in slot0, and the requester holds flush_req.
- fwd_x_sel/fwd_y_sel are loaded only when issue_ready=1. They are cleared when slot0 is loaded with a bubble, and hold during Memory stall and Frozen cycles.
- wb_valid and wb_rd are combinational from slot D-1. occupancy is combinational.

## Timing
- While Reset is high: all slots invalid; fwd sels 0; stall_cycles 0; issue_ready, wb_valid and occupancy 0.
- Reset mid-operation discards all in-flight records immediately.
- issue_ready is combinational from the inputs and current slots, with zero latency. Decode samples it in the same cycle.
- The fwd sel pair is valid in the cycle after acceptance, when the consumer is in Execute.
- A load in slot0 followed by a dependent issue costs exactly 1 bubble for MEM_STAGE=3, and MEM_STAGE-2 bubbles in general.
- A waitreq held N cycles freezes Decode..Memory for N cycles and inserts N bubbles behind Memory.

## Configuration
- PIPE_STALL_CNT_EN defined:
  - stall_cycles is a 16-bit saturating counter.
  - It increments on every non-Frozen cycle with issue_valid=1 and issue_ready=0 that is not a Flush cycle.
  - It holds at 16'hFFFF.
- PIPE_STALL_CNT_EN undefined: stall_cycles is constant 0 and the counter logic is absent.

## Test plan
- Back-to-back ALU chain: add r1 then add r2,r1 -> both issue_ready=1; second gets fwd_x_sel=3 in its Execute cycle. Three-apart dependency -> sel 0.
- Load-use: ld r3 then add r4,r3 -> one cycle issue_ready=0, slot0 bubble (occupancy 3'b010), next cycle accepted with fwd_x_sel=4.
- Memory wait: store in Memory, mem_waitreq high 3 cycles -> occupancy[1:0] frozen for 3 cycles, bubble in Writeback each cycle, issue_ready=0, stall_cycles=3 with macro.
- Flush: flush_req with valid Decode instruction -> issue_ready=0, slot0 bubble, branch moves to Memory. Flush concurrent with waitreq -> ignored, branch stays in slot0.
- Writeback and reset: instruction with rd=5, wb=1 reaches slot D-1 -> wb_valid=1, wb_rd=5. Reset asserted mid-stream -> all outputs 0 asynchronously.
- Enable=0 for 2 cycles with pending hazards -> no slot, sel or counter change; resumes identically.

Source files
------------

// File: rtl/pipe_hazard_unit_if.sv
// pipe_hazard_unit_if: decode issue, memory/branch requests and hazard-unit results.
// master = decode/pipeline side, slave = pipe_hazard_unit.
interface pipe_hazard_unit_if #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_REGS   = 8
);
    localparam int REG_BITS   = $clog2(NUM_REGS);
    localparam int STAGE_BITS = $clog2(NUM_STAGES);
    localparam int D          = NUM_STAGES - 2;
    logic                  en;
    logic                  issue_valid;
    logic [REG_BITS-1:0]   issue_rd;
    logic                  issue_wb;
    logic                  issue_load;
    logic                  issue_store;
    logic [REG_BITS-1:0]   issue_rx;
    logic [REG_BITS-1:0]   issue_ry;
    logic                  issue_use_rx;
    logic                  issue_use_ry;
    logic                  mem_waitreq;
    logic                  flush_req;
    logic                  issue_ready;
    logic [STAGE_BITS-1:0] fwd_x_sel;
    logic [STAGE_BITS-1:0] fwd_y_sel;
    logic [D-1:0]          occupancy;
    logic                  wb_valid;
    logic [REG_BITS-1:0]   wb_rd;
    logic [15:0]           stall_cycles;
    modport master (
        output en, issue_valid, issue_rd, issue_wb, issue_load, issue_store,
               issue_rx, issue_ry, issue_use_rx, issue_use_ry, mem_waitreq, flush_req,
        input  issue_ready, fwd_x_sel, fwd_y_sel, occupancy, wb_valid, wb_rd, stall_cycles
    );
    modport slave (
        input  en, issue_valid, issue_rd, issue_wb, issue_load, issue_store,
               issue_rx, issue_ry, issue_use_rx, issue_use_ry, mem_waitreq, flush_req,
        output issue_ready, fwd_x_sel, fwd_y_sel, occupancy, wb_valid, wb_rd, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: tracks Execute..Writeback slots, issues/interlocks Decode, flushes, forwarding.
// Optional PIPE_STALL_CNT_EN adds a saturating 16-bit stall counter.
module pipe_hazard_unit #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_REGS   = 8,
    parameter int MEM_STAGE  = 3
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_unit_if.slave bus
);
    localparam int REG_BITS   = $clog2(NUM_REGS);
    localparam int STAGE_BITS = $clog2(NUM_STAGES);
    localparam int D          = NUM_STAGES - 2;
    localparam int M          = MEM_STAGE - 2;

    typedef struct packed {
        logic                valid;
        logic                wb;
        logic                load;
        logic                store;
        logic [REG_BITS-1:0] rd;
    } slot_t;

    slot_t                 slots [D];
    slot_t                 nxt   [D];
    slot_t                 issue_rec;
    logic                  active, mem_stall, flush, load_use, normal, advance;
    logic                  hz_x, hz_y;
    logic [STAGE_BITS-1:0] sel_x, sel_y, fwd_x, fwd_y;

    // Scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
        hz_x  = 1'b0;
        hz_y  = 1'b0;
        sel_x = '0;
        sel_y = '0;
        for (int j = D - 1; j >= 0; j--) begin
            if (bus.issue_use_rx && slots[j].valid && slots[j].wb && slots[j].rd == bus.issue_rx) begin
                hz_x  = slots[j].load && (j + 3 <= MEM_STAGE);
                sel_x = (j + 3 < NUM_STAGES) ? STAGE_BITS'(j + 3) : '0;
            end
            if (bus.issue_use_ry && slots[j].valid && slots[j].wb && slots[j].rd == bus.issue_ry) begin
                hz_y  = slots[j].load && (j + 3 <= MEM_STAGE);
                sel_y = (j + 3 < NUM_STAGES) ? STAGE_BITS'(j + 3) : '0;
            end
        end
    end

    assign active          = bus.en && !rst;
    assign mem_stall       = active && bus.mem_waitreq && slots[M].valid && (slots[M].load || slots[M].store);
    assign flush           = active && !mem_stall && bus.flush_req;
    assign load_use        = active && !mem_stall && !flush && bus.issue_valid && (hz_x || hz_y);
    assign normal          = active && !mem_stall && !flush && !load_use;
    assign advance         = active && !mem_stall;
    assign bus.issue_ready = normal && bus.issue_valid;
    assign issue_rec       = bus.issue_ready ? {1'b1, bus.issue_wb, bus.issue_load, bus.issue_store, bus.issue_rd} : '0;

    // A memory stall holds Decode..Memory and drains a bubble into the stage behind it.
    always_comb begin
        nxt = slots;
        if (advance) begin
            nxt[0] = issue_rec;
            for (int j = 1; j < D; j++) nxt[j] = slots[j-1];
        end else if (mem_stall) begin
            for (int j = M + 1; j < D; j++) nxt[j] = (j == M + 1) ? '0 : slots[j-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < D; j++) slots[j] <= '0;
            fwd_x <= '0;
            fwd_y <= '0;
        end else begin
            slots <= nxt;
            if (advance) begin
                fwd_x <= bus.issue_ready ? sel_x : '0;
                fwd_y <= bus.issue_ready ? sel_y : '0;
            end
        end
    end

    always_comb begin
        bus.occupancy = '0;
        for (int j = 0; j < D; j++) bus.occupancy[j] = slots[j].valid;
    end

    assign bus.fwd_x_sel = fwd_x;
    assign bus.fwd_y_sel = fwd_y;
    assign bus.wb_valid  = slots[D-1].valid && slots[D-1].wb;
    assign bus.wb_rd     = slots[D-1].rd;

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (active && bus.issue_valid && !bus.issue_ready && !flush && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign bus.stall_cycles = cnt;
`else
    assign bus.stall_cycles = 16'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed scenarios plus random traffic against a stage-indexed pipeline model.
module tb_pipe_hazard_unit;
    localparam int NS = 5, NR = 8, MEM = 3;
`ifdef PIPE_STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0;
    int total = 0, bad = 0;

    pipe_hazard_unit_if #(.NUM_STAGES(NS), .NUM_REGS(NR)) bus ();
    pipe_hazard_unit #(.NUM_STAGES(NS), .NUM_REGS(NR), .MEM_STAGE(MEM)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic en, iv;
        logic [2:0] rd;
        logic wb, ld, st;
        logic [2:0] rx, ry;
        logic ux, uy, wr, fl;
    } in_t;

    // Model: one record per pipeline stage number (2 = Execute .. NS-1 = Writeback).
    bit m_v[NS], m_wb[NS], m_ld[NS], m_st[NS];
    int m_rd[NS];
    int m_fx, m_fy, m_cnt;
    logic obs_ready;
    bit exp_ready;

    function automatic in_t op(int rd, bit wb, bit ld, bit st, int rx, bit ux, int ry, bit uy);
        in_t x = '0;
        x.en = 1'b1; x.iv = 1'b1; x.rd = 3'(rd); x.wb = wb; x.ld = ld; x.st = st;
        x.rx = 3'(rx); x.ux = ux; x.ry = 3'(ry); x.uy = uy;
        return x;
    endfunction

    function automatic in_t idle();
        in_t x = '0;
        x.en = 1'b1;
        return x;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) begin
            m_v[s] = 0; m_wb[s] = 0; m_ld[s] = 0; m_st[s] = 0; m_rd[s] = 0;
        end
        m_fx = 0; m_fy = 0; m_cnt = 0;
    endfunction

    function automatic void mv(int s);
        m_v[s] = m_v[s-1]; m_wb[s] = m_wb[s-1]; m_ld[s] = m_ld[s-1]; m_st[s] = m_st[s-1]; m_rd[s] = m_rd[s-1];
    endfunction

    // The consumer reaches Execute when its nearest producer sits one stage further on;
    // a load there has not left Memory yet if that stage is <= MEM.
    function automatic void m_search(input int src, input bit u, output bit hz, output int sel);
        bit found = 0;
        hz = 0; sel = 0;
        for (int s = 2; s < NS; s++)
            if (!found && u && m_v[s] && m_wb[s] && m_rd[s] == src) begin
                found = 1;
                hz = m_ld[s] && (s + 1 <= MEM);
                sel = (hz || s + 1 >= NS) ? 0 : s + 1;
            end
    endfunction

    task automatic drive(input in_t x);
        bus.en = x.en; bus.issue_valid = x.iv; bus.issue_rd = x.rd; bus.issue_wb = x.wb;
        bus.issue_load = x.ld; bus.issue_store = x.st; bus.issue_rx = x.rx; bus.issue_ry = x.ry;
        bus.issue_use_rx = x.ux; bus.issue_use_ry = x.uy; bus.mem_waitreq = x.wr; bus.flush_req = x.fl;
    endtask

    task automatic step(input in_t x);
        bit hx, hy, ms, fl;
        int sx, sy;
        drive(x);
        #2;
        obs_ready = bus.issue_ready;
        m_search(int'(x.rx), x.ux, hx, sx);
        m_search(int'(x.ry), x.uy, hy, sy);
        ms = x.en && x.wr && m_v[MEM] && (m_ld[MEM] || m_st[MEM]);
        fl = x.en && !ms && x.fl;
        exp_ready = x.en && !ms && !fl && x.iv && !hx && !hy;
        @(posedge clk);
        #1;
        if (x.en) begin
            if (CNT_ON && x.iv && !exp_ready && !fl && m_cnt < 65535) m_cnt++;
            if (ms) begin
                for (int s = NS - 1; s > MEM + 1; s--) mv(s);
                if (MEM + 1 < NS) m_v[MEM+1] = 0;
            end else begin
                m_fx = exp_ready ? sx : 0;
                m_fy = exp_ready ? sy : 0;
                for (int s = NS - 1; s > 2; s--) mv(s);
                m_v[2] = exp_ready; m_wb[2] = x.wb; m_ld[2] = x.ld; m_st[2] = x.st; m_rd[2] = int'(x.rd);
            end
        end
    endtask

    task automatic do_reset();
        drive(idle());
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(op(1, 1, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        total++; if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bus.issue_ready); end
        total++; if (bus.occupancy !== 3'b000) begin bad++; $display("FAIL rst_occ got=%b exp=000", bus.occupancy); end
        total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb got=%b exp=0", bus.wb_valid); end
        total++; if (bus.fwd_x_sel !== 3'd0 || bus.fwd_y_sel !== 3'd0) begin bad++; $display("FAIL rst_fwd got=%0d/%0d exp=0/0", bus.fwd_x_sel, bus.fwd_y_sel); end
        total++; if (bus.stall_cycles !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", bus.stall_cycles); end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(op(1, 1, 0, 0, 0, 0, 0, 0));
        total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL bb_ready1 got=%b exp=1", obs_ready); end
        step(op(2, 1, 0, 0, 1, 1, 0, 0));
        total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL bb_ready2 got=%b exp=1", obs_ready); end
        total++; if (bus.fwd_x_sel !== 3'd3) begin bad++; $display("FAIL bb_fwd_x got=%0d exp=3", bus.fwd_x_sel); end
        step(op(5, 1, 0, 0, 0, 0, 0, 0));
        step(op(6, 1, 0, 0, 0, 0, 0, 0));
        step(op(7, 1, 0, 0, 0, 0, 0, 0));
        step(op(0, 1, 0, 0, 6, 1, 5, 1));
        total++; if (bus.fwd_x_sel !== 3'd4 || bus.fwd_y_sel !== 3'd0) begin bad++; $display("FAIL bb_two_three got=%0d/%0d exp=4/0", bus.fwd_x_sel, bus.fwd_y_sel); end
        step(op(1, 0, 0, 0, 0, 1, 7, 1));
        total++; if (bus.fwd_x_sel !== 3'd3 || bus.fwd_y_sel !== 3'd4) begin bad++; $display("FAIL bb_r0 got=%0d/%0d exp=3/4", bus.fwd_x_sel, bus.fwd_y_sel); end
        total++; if (bus.stall_cycles !== 16'd0) begin bad++; $display("FAIL bb_cnt got=%0d exp=0", bus.stall_cycles); end
    endtask

    task automatic test_load_use();
        do_reset();
        step(op(3, 1, 1, 0, 0, 0, 0, 0));
        step(op(4, 1, 0, 0, 3, 1, 0, 0));
        total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL lu_ready got=%b exp=0", obs_ready); end
        total++; if (bus.occupancy !== 3'b010) begin bad++; $display("FAIL lu_occ got=%b exp=010", bus.occupancy); end
        total++; if (bus.fwd_x_sel !== 3'd0) begin bad++; $display("FAIL lu_fwd0 got=%0d exp=0", bus.fwd_x_sel); end
        step(op(4, 1, 0, 0, 3, 1, 0, 0));
        total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL lu_ready2 got=%b exp=1", obs_ready); end
        total++; if (bus.fwd_x_sel !== 3'd4) begin bad++; $display("FAIL lu_fwd got=%0d exp=4", bus.fwd_x_sel); end
        total++; if (bus.occupancy !== 3'b101) begin bad++; $display("FAIL lu_occ2 got=%b exp=101", bus.occupancy); end
        total++; if (bus.stall_cycles !== 16'(CNT_ON ? 1 : 0)) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", bus.stall_cycles, CNT_ON ? 1 : 0); end
    endtask

    task automatic test_mem_wait();
        in_t x;
        do_reset();
        step(op(5, 1, 0, 0, 0, 0, 0, 0));
        step(op(0, 0, 0, 1, 0, 0, 0, 0));
        step(op(1, 1, 0, 0, 0, 0, 0, 0));
        total++; if (bus.occupancy !== 3'b111) begin bad++; $display("FAIL mw_pre got=%b exp=111", bus.occupancy); end
        x = op(2, 1, 0, 0, 0, 0, 0, 0);
        x.wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(x);
            total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL mw_ready%0d got=%b exp=0", i, obs_ready); end
            total++; if (bus.occupancy !== 3'b011) begin bad++; $display("FAIL mw_occ%0d got=%b exp=011", i, bus.occupancy); end
        end
        total++; if (bus.stall_cycles !== 16'(CNT_ON ? 3 : 0)) begin bad++; $display("FAIL mw_cnt got=%0d exp=%0d", bus.stall_cycles, CNT_ON ? 3 : 0); end
        x.wr = 1'b0;
        step(x);
        total++; if (obs_ready !== 1'b1 || bus.occupancy !== 3'b111) begin bad++; $display("FAIL mw_resume got=%b/%b exp=1/111", obs_ready, bus.occupancy); end
    endtask

    task automatic test_flush();
        in_t x;
        do_reset();
        step(op(0, 0, 0, 0, 0, 0, 0, 0));
        x = op(1, 1, 0, 0, 0, 0, 0, 0);
        x.fl = 1'b1;
        step(x);
        total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got=%b exp=0", obs_ready); end
        total++; if (bus.occupancy !== 3'b010) begin bad++; $display("FAIL fl_occ got=%b exp=010", bus.occupancy); end
        do_reset();
        step(op(0, 0, 0, 1, 0, 0, 0, 0));
        step(op(0, 0, 0, 0, 0, 0, 0, 0));
        x.wr = 1'b1;
        step(x);
        total++; if (obs_ready !== 1'b0 || bus.occupancy !== 3'b011) begin bad++; $display("FAIL fl_wait got=%b/%b exp=0/011", obs_ready, bus.occupancy); end
        x.wr = 1'b0;
        step(x);
        total++; if (obs_ready !== 1'b0 || bus.occupancy !== 3'b110) begin bad++; $display("FAIL fl_after got=%b/%b exp=0/110", obs_ready, bus.occupancy); end
        total++; if (bus.stall_cycles !== 16'(CNT_ON ? 1 : 0)) begin bad++; $display("FAIL fl_cnt got=%0d exp=%0d", bus.stall_cycles, CNT_ON ? 1 : 0); end
    endtask

    task automatic test_writeback_reset();
        do_reset();
        step(op(5, 1, 0, 0, 0, 0, 0, 0));
        step(op(6, 1, 0, 0, 5, 1, 0, 0));
        total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL wb_early got=%b exp=0", bus.wb_valid); end
        step(op(7, 1, 0, 0, 6, 1, 0, 0));
        total++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 3'd5) begin bad++; $display("FAIL wb_rd got=%b/%0d exp=1/5", bus.wb_valid, bus.wb_rd); end
        total++; if (bus.fwd_x_sel !== 3'd3) begin bad++; $display("FAIL wb_fwd got=%0d exp=3", bus.fwd_x_sel); end
        drive(op(1, 1, 0, 0, 0, 0, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.issue_ready !== 1'b0 || bus.occupancy !== 3'b000 || bus.wb_valid !== 1'b0) begin bad++; $display("FAIL ar_outs got=%b/%b/%b exp=0/000/0", bus.issue_ready, bus.occupancy, bus.wb_valid); end
        total++; if (bus.fwd_x_sel !== 3'd0 || bus.stall_cycles !== 16'd0) begin bad++; $display("FAIL ar_regs got=%0d/%0d exp=0/0", bus.fwd_x_sel, bus.stall_cycles); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_enable();
        in_t x;
        do_reset();
        step(op(2, 1, 0, 0, 0, 0, 0, 0));
        step(op(3, 1, 1, 0, 2, 1, 0, 0));
        x = op(4, 1, 0, 0, 3, 1, 0, 0);
        x.en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(x);
            total++; if (obs_ready !== 1'b0 || bus.occupancy !== 3'b011) begin bad++; $display("FAIL en_frz%0d got=%b/%b exp=0/011", i, obs_ready, bus.occupancy); end
            total++; if (bus.fwd_x_sel !== 3'd3 || bus.stall_cycles !== 16'd0) begin bad++; $display("FAIL en_hold%0d got=%0d/%0d exp=3/0", i, bus.fwd_x_sel, bus.stall_cycles); end
        end
        x.en = 1'b1;
        step(x);
        total++; if (obs_ready !== 1'b0 || bus.occupancy !== 3'b110) begin bad++; $display("FAIL en_lu got=%b/%b exp=0/110", obs_ready, bus.occupancy); end
        step(x);
        total++; if (obs_ready !== 1'b1 || bus.fwd_x_sel !== 3'd4) begin bad++; $display("FAIL en_resume got=%b/%0d exp=1/4", obs_ready, bus.fwd_x_sel); end
        total++; if (bus.stall_cycles !== 16'(CNT_ON ? 1 : 0)) begin bad++; $display("FAIL en_cnt got=%0d exp=%0d", bus.stall_cycles, CNT_ON ? 1 : 0); end
    endtask

    task automatic test_random();
        in_t x;
        int k;
        logic [NS-3:0] eo;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            x = '0;
            x.en = ($urandom_range(0, 9) != 0);
            x.iv = ($urandom_range(0, 4) != 0);
            x.rd = 3'($urandom_range(0, 3));
            x.wb = ($urandom_range(0, 3) != 0);
            k = int'($urandom_range(0, 3));
            x.ld = (k == 0);
            x.st = (k == 1);
            x.rx = 3'($urandom_range(0, 3));
            x.ry = 3'($urandom_range(0, 3));
            x.ux = ($urandom_range(0, 2) != 0);
            x.uy = ($urandom_range(0, 2) != 0);
            x.wr = ($urandom_range(0, 3) == 0);
            x.fl = ($urandom_range(0, 7) == 0);
            step(x);
            for (int s = 2; s < NS; s++) eo[s-2] = m_v[s];
            total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, obs_ready, exp_ready); end
            total++; if (bus.occupancy !== eo) begin bad++; $display("FAIL rnd_occ[%0d] got=%b exp=%b", i, bus.occupancy, eo); end
            total++; if (bus.wb_valid !== (m_v[NS-1] && m_wb[NS-1])) begin bad++; $display("FAIL rnd_wb[%0d] got=%b exp=%b", i, bus.wb_valid, m_v[NS-1] && m_wb[NS-1]); end
            if (m_v[NS-1] && m_wb[NS-1]) begin
                total++; if (int'(bus.wb_rd) != m_rd[NS-1]) begin bad++; $display("FAIL rnd_wbrd[%0d] got=%0d exp=%0d", i, bus.wb_rd, m_rd[NS-1]); end
            end
            total++; if (int'(bus.fwd_x_sel) != m_fx || int'(bus.fwd_y_sel) != m_fy) begin bad++; $display("FAIL rnd_fwd[%0d] got=%0d/%0d exp=%0d/%0d", i, bus.fwd_x_sel, bus.fwd_y_sel, m_fx, m_fy); end
            total++; if (int'(bus.stall_cycles) != m_cnt) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, bus.stall_cycles, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_mem_wait();
        test_flush();
        test_writeback_reset();
        test_enable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
